seven_seg_scanner: RTL
======================

Name: seven_seg_scanner

Overview:
- Parametrised multiplexed seven-segment driver with NUM_DIGITS digits.
- Time-multiplexes hex nibbles onto shared active-low cathodes, adding decimal points, per-digit enables, optional leading-zero blanking, anti-ghosting dead time and PWM brightness.
- Inputs are double-buffered and sampled once per frame, so the display never shows a mix of old and new values.
- Sits between user logic (debug values, counters) and board display pins.

Parameters:
- NUM_DIGITS, 8, number of digits scanned; legal range 1..16.
- REFRESH_CYCLES, 100_000, clock cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 1000, dead-time cycles at the start of each slot with all anodes off; must be < REFRESH_CYCLES (0 disables dead time).
- BRIGHT_W, 4, width of the brightness control.

Ports:
- clk_in, input, 1, system clock.
- rst_n_in, input, 1, reset: asynchronous, active-low.
- val_in, input, 4*NUM_DIGITS, hex nibbles; digit k = val_in[4k+3:4k]; digit 0 is rightmost.
- dp_in, input, NUM_DIGITS, decimal point per digit, active-high.
- digit_en_in, input, NUM_DIGITS, per-digit enable; 0 forces that anode off.
- lz_blank_in, input, 1, 1 = blank leading zero digits.
- brightness_in, input, BRIGHT_W, PWM level; 0 = off, all-ones = full on.
- cat_out, output, 7, active-low segments: [0]=a, [1]=b, … [6]=g.
- dp_out, output, 1, active-low decimal point.
- an_out, output, NUM_DIGITS, active-low anodes; bit k = digit k.
- frame_out, output, 1, one-cycle pulse when new inputs are latched (frame boundary).

Behaviour:
- Reset (rst_n_in low, asynchronous):
  - Outputs: an_out all ones, cat_out 7'h7F, dp_out 1, frame_out 0.
  - Internal state: slot_cnt 0, digit_idx 0, pwm_cnt 0, shadow registers cleared.
  - Outputs change immediately on reset assertion, without waiting for a clock edge.
  - Operation resumes on the first clock edge after release, starting at slot_cnt 0, digit_idx 0.
- slot_cnt:
  - Counts 0..REFRESH_CYCLES-1 and wraps to 0.
  - On wrap, digit_idx increments; it wraps from NUM_DIGITS-1 to 0.
- Frame latch: on the cycle where slot_cnt == REFRESH_CYCLES-1 and digit_idx == NUM_DIGITS-1:
  - Shadow registers capture val_in, dp_in, digit_en_in, lz_blank_in and brightness_in.
  - frame_out is 1 on the following cycle, which is the first cycle of digit 0's slot.
  - Input changes at any other time are not displayed until the next latch.
- First frame after reset: the shadows hold zeros, so the display is dark because brightness is 0. The first latch occurs after NUM_DIGITS*REFRESH_CYCLES cycles.
- pwm_cnt:
  - Free-running BRIGHT_W-bit counter; pwm_on = (pwm_cnt < shadow brightness).
  - Exception: shadow brightness all-ones forces pwm_on = 1, giving 100% duty.
- Leading-zero blank: when shadow lz_blank = 1, digit k is blanked if it is above digit 0 and its nibble and every higher digit's nibble are 0. Digit 0 is never blanked.
- Digit k = digit_idx is lit in a cycle iff all of the following hold:
  - slot_cnt >= BLANK_CYCLES;
  - shadow digit_en[k] is 1;
  - digit k is not leading-zero blanked;
  - pwm_on is 1.
- Output encoding:
  - Lit digit: an_out has only bit k low; cat_out = ~hexdecode(nibble k); dp_out = ~shadow dp[k].
  - Not lit: an_out all ones, cat_out 7'h7F, dp_out 1.
- Hex decode (active-high before inversion, g..a):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
- Output timing: all outputs are registered, with one cycle of latency from the counter state that produces them. There are no combinational paths from inputs to outputs.
- Guarantee: at most one an_out bit is low in any cycle.
- NUM_DIGITS=1: digit_idx is fixed at 0, and a latch occurs on every slot wrap.

Test Plan:
- Base parameters NUM_DIGITS=4, REFRESH_CYCLES=8, BLANK_CYCLES=2, BRIGHT_W=2.
- Basic scan: val_in=16'h3210, dp_in=4'b0000, enables 4'hF, brightness 3, lz 0; wait one frame → in each slot, an_out goes low one-hot (1110, 1101, 1011, 0111) for 6 cycles after 2 dead cycles. cat_out is 1000000 / 1111001 / 0100100 / 0110000 for digits 0..3; frame_out pulses every 32 cycles.
- Leading zero: val_in=16'h0050, lz 1 → digits 3 and 2 are never lit; digits 1 and 0 are lit, digit 1 showing 0010010 ("5"). Repeat with val_in=16'h0000 → only digit 0 lit, showing 1000000.
- Enable/dp: digit_en_in=4'b1010, dp_in=4'b0010 → anodes 0 and 2 stay high; dp_out is 0 only while digit 1 is lit.
- Brightness: level 0 → an_out is 4'hF throughout. Level 1 → per slot, anode low exactly when pwm_cnt==0 (25% duty) during the non-dead window. Level 3 → low for all 6 non-dead cycles.
- Shadow latch: change val_in from 16'h1111 to 16'h2222 mid-frame → cat_out shows "1" until the frame_out pulse, then "2" on all digits from the next slot onward.
- Async reset: assert rst_n_in mid-slot, between clock edges → an_out=4'hF, cat_out=7'h7F, dp_out=1 with no clock edge. After release, scanning restarts at digit 0 with the display dark for the first frame.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment driver: scans NUM_DIGITS hex digits onto shared
// active-low cathodes with dead time, PWM dimming and frame-latched inputs.
module seven_seg_scanner #(
    parameter int NUM_DIGITS     = 8,
    parameter int REFRESH_CYCLES = 100_000,
    parameter int BLANK_CYCLES   = 1000,
    parameter int BRIGHT_W       = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [4*NUM_DIGITS-1:0] val_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en_in,
    input  logic                    lz_blank_in,
    input  logic [BRIGHT_W-1:0]     brightness_in,
    output logic [6:0]              cat_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_out
);

    localparam int SLOT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic [DIG_W-1:0]        digit_q, digit_d;
    logic [BRIGHT_W-1:0]     pwm_q;
    logic [4*NUM_DIGITS-1:0] val_sh_q;
    logic [NUM_DIGITS-1:0]   dp_sh_q;
    logic [NUM_DIGITS-1:0]   en_sh_q;
    logic                    lz_sh_q;
    logic [BRIGHT_W-1:0]     bright_sh_q;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              cat_q, cat_d;
    logic                    dp_q, dp_d;
    logic                    frame_q;

    logic                    slot_wrap, digit_last, latch;
    logic                    pwm_on, lit;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [3:0]              nibble;

    // Active-high segment pattern, bit order g..a.
    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_seg = 7'b0111111;
            4'h1: hex_seg = 7'b0000110;
            4'h2: hex_seg = 7'b1011011;
            4'h3: hex_seg = 7'b1001111;
            4'h4: hex_seg = 7'b1100110;
            4'h5: hex_seg = 7'b1101101;
            4'h6: hex_seg = 7'b1111101;
            4'h7: hex_seg = 7'b0000111;
            4'h8: hex_seg = 7'b1111111;
            4'h9: hex_seg = 7'b1101111;
            4'hA: hex_seg = 7'b1110111;
            4'hB: hex_seg = 7'b1111100;
            4'hC: hex_seg = 7'b0111001;
            4'hD: hex_seg = 7'b1011110;
            4'hE: hex_seg = 7'b1111001;
            default: hex_seg = 7'b1110001;
        endcase
    endfunction

    assign slot_wrap  = (slot_q == SLOT_W'(REFRESH_CYCLES - 1));
    assign digit_last = (digit_q == DIG_W'(NUM_DIGITS - 1));
    assign latch      = slot_wrap && digit_last;

    assign slot_d  = slot_wrap ? '0 : slot_q + 1'b1;
    assign digit_d = !slot_wrap ? digit_q : (digit_last ? '0 : digit_q + 1'b1);

    assign pwm_on = (&bright_sh_q) || (pwm_q < bright_sh_q);
    assign nibble = val_sh_q[int'(digit_q)*4 +: 4];

    // Walk from the most significant digit down; a digit is blanked while every
    // nibble from the top down to it is zero. Digit 0 always stays visible.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (val_sh_q[4*k +: 4] == 4'h0);
            if (k != 0) begin
                lz_mask[k] = lz_sh_q && zero_run;
            end
        end
    end

    always_comb begin
        an_d  = '1;
        cat_d = 7'h7F;
        dp_d  = 1'b1;
        lit   = (slot_q >= SLOT_W'(BLANK_CYCLES)) && en_sh_q[digit_q] &&
                !lz_mask[digit_q] && pwm_on;
        if (lit) begin
            an_d  = ~(NUM_DIGITS'(1) << digit_q);
            cat_d = ~hex_seg(nibble);
            dp_d  = ~dp_sh_q[digit_q];
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            slot_q      <= '0;
            digit_q     <= '0;
            pwm_q       <= '0;
            val_sh_q    <= '0;
            dp_sh_q     <= '0;
            en_sh_q     <= '0;
            lz_sh_q     <= 1'b0;
            bright_sh_q <= '0;
            an_q        <= '1;
            cat_q       <= 7'h7F;
            dp_q        <= 1'b1;
            frame_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others, independent of statement order.
            slot_q  <= slot_d;
            digit_q <= digit_d;
            pwm_q   <= pwm_q + 1'b1;
            if (latch) begin
                val_sh_q    <= val_in;
                dp_sh_q     <= dp_in;
                en_sh_q     <= digit_en_in;
                lz_sh_q     <= lz_blank_in;
                bright_sh_q <= brightness_in;
            end
            an_q    <= an_d;
            cat_q   <= cat_d;
            dp_q    <= dp_d;
            frame_q <= latch;
        end
    end

    assign an_out    = an_q;
    assign cat_out   = cat_q;
    assign dp_out    = dp_q;
    assign frame_out = frame_q;

endmodule
